// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The serial core's state enum, slice width and counter sizing live here.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

  localparam int NSA_NIBBLE_W = 4;

  // Nibble counter width: clog2(nibbles), never narrower than one bit.
  function automatic int nsa_cnt_w(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/ripplecarry4bit.sv
// Existing 4-bit ripple-carry slice: {cout, sum} = a + b + cin.
module ripplecarry4bit (
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit a+b+cin computed one nibble per clock through a single 4-bit slice.
// Optional signed-overflow output is built when NSA_OVERFLOW_EN is defined.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NSA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIBBLES = WIDTH / NSA_NIBBLE_W;
  localparam int CNT_W   = nsa_cnt_w(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  nsa_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_sum_sh, r_sum;
  logic             r_carry, r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       w_s4;
  logic             w_c4;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_accept, w_last;

  ripplecarry4bit u_slice (
    .sum  (w_s4),
    .cout (w_c4),
    .a    (r_a_sh[3:0]),
    .b    (r_b_sh[3:0]),
    .cin  (r_carry)
  );

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign w_sum_next = (r_sum_sh >> NSA_NIBBLE_W) | (WIDTH'(w_s4) << (WIDTH - NSA_NIBBLE_W));
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_last     = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (r_cnt == LAST) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign in_ready = rst_n && (r_state == IDLE);
  assign sum      = r_sum;
  assign cout     = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a_sh   <= r_a_sh >> NSA_NIBBLE_W;
        r_b_sh   <= r_b_sh >> NSA_NIBBLE_W;
        r_sum_sh <= w_sum_next;
        r_carry  <= w_c4;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_c4;
      end
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic r_a_msb, r_b_msb, r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      if (w_last)
        r_ovf <= (r_a_msb == r_b_msb) && (w_sum_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that computes WIDTH-bit `a + b + cin` by streaming one 4-bit nibble per clock through a single 4-bit ripple-carry slice. A carry register chains the slices, and a shift register collects the sum nibbles. It sits around the existing 4-bit adder: it feeds operand nibbles and the carry into the adder and consumes its sum and carry-out. A valid/ready handshake on both sides lets it drop into a datapath pipeline.

## Interface
- `WIDTH`, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset. One clock domain; reset polarity and synchronicity are fixed.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands. High only in IDLE and forced 0 while `rst_n`=0.
- `a` input WIDTH: operand A, unsigned or two's complement.
- `b` input WIDTH: operand B.
- `cin` input 1: carry into bit 0.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: result bits [WIDTH-1:0].
- `cout` output 1: carry out of bit WIDTH-1.
- `ovf` output 1: signed overflow. Present only with NSA_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_valid`&&`in_ready` latches `a`→a_sh, `b`→b_sh, `cin`→carry, and cnt=0.
  - It also latches a[WIDTH-1] and b[WIDTH-1] for overflow detection. Next state is RUN.
  - With `in_valid`=0 the block stays in IDLE.
- RUN, each cycle:
  - The slice adds a_sh[3:0], b_sh[3:0] and carry, giving s4 and c4.
  - sum_sh ← {s4, sum_sh[WIDTH-1:4]}. a_sh and b_sh shift right by 4. carry ← c4. cnt ← cnt+1.
  - On cnt==NIBBLES-1 the output registers load: `sum`←final sum_sh (including this cycle's s4), `cout`←c4, and `ovf` when enabled. Next state is DONE.
- DONE:
  - `out_valid`=1. `sum`, `cout` and `ovf` are held stable.
  - `out_ready`=1 → IDLE.
  - `out_ready`=0 → stay in DONE indefinitely. No data is lost.
- Arithmetic is modulo 2^WIDTH, and `cout` is the true carry of the full WIDTH-bit add. Example: 0xFFFF+0x0000+1 gives `sum`=0x0000, `cout`=1.
- `in_valid` outside IDLE is ignored. Operand inputs are don't-care outside the accept cycle.
- `a`, `b` and `cin` changing during RUN has no effect.
- Reset mid-operation: all state is cleared immediately. The in-flight operation is discarded and no partial result is presented.
- The cnt width is clog2(NIBBLES), minimum 1 bit.

## Timing
- Reset values: `in_ready`=0 while in reset, then 1 from the first cycle after `rst_n` deasserts. `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Latency: operands accepted at edge E0 give `out_valid`=1 after edge E0+NIBBLES. For WIDTH=16 that is 4 cycles; for WIDTH=4 it is 1 cycle.
- Throughput: at most one operation per NIBBLES+2 cycles.
- `in_ready` is low in RUN and DONE, so accept and output handshakes never coincide.
- `sum`, `cout` and `ovf` change only on entry to DONE. They hold their last result in IDLE and RUN.
- All outputs are registered or decoded from state only. There is no combinational input→output path.

## Configuration
- Macro: `NSA_OVERFLOW_EN`.
- Defined:
  - The `ovf` port exists.
  - `ovf` = (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb), registered on entry to DONE.
- Undefined: there is no `ovf` port and no MSB capture registers. All other behaviour is identical.

## Structure
- Package `nsa_pkg`:
  - state enum `nsa_state_t` {IDLE, RUN, DONE};
  - `NSA_NIBBLE_W`=4;
  - a function for the cnt width.
- Sub-module: one instance of the team's existing `ripplecarry4bit` as the nibble slice. Its ports are `sum[3:0]`, `cout`, `a[3:0]`, `b[3:0]` and `cin`. No other sub-modules.

## Test plan
- **Full-width carry (WIDTH=16):** a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1. `out_valid` rises exactly 4 cycles after the accept edge.
- **Nibble carry chain:** a=0x1234, b=0x4321, cin=1 → `sum`=0x5556, `cout`=0. Also 0x0FFF+0x0001 → 0x1000, which checks carry propagation across nibbles.
- **Backpressure:**
  - Hold `out_ready`=0 for 6 cycles in DONE → `sum`/`cout` stable and `in_ready`=0.
  - A new `in_valid` pulse during DONE is ignored.
  - Release `out_ready` → IDLE, with `in_ready`=1 the next cycle.
- **Reset mid-RUN:** assert `rst_n`=0 after 2 RUN cycles → outputs immediately 0, state IDLE. The next operation, 0x0003+0x0004, gives 0x0007.
- **NSA_OVERFLOW_EN:**
  - 0x7FFF+0x0001 → `sum`=0x8000, `ovf`=1, `cout`=0.
  - 0x8000+0x8000 → `sum`=0x0000, `ovf`=1, `cout`=1.
  - 0x0001+0xFFFF → `ovf`=0.
- **WIDTH=4 corner:** a=0xF, b=0xF, cin=1 → `sum`=0xF, `cout`=1 with latency 1. Back-to-back operations are accepted every 3 cycles.
